// File: rtl/bsg_mul_op_pkg.sv
// ============================================================================
// bsg_mul_op_pkg : op codes and sequencer states for bsg_mul_op_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package bsg_mul_op_pkg;

  localparam int OP_WIDTH    = 3;
  localparam int STATE_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    eMul    = 3'd0,
    eMulh   = 3'd1,
    eMulhsu = 3'd2,
    eMulhu  = 3'd3,
    eMulw   = 3'd4
  } mul_op_e;

  typedef enum logic [STATE_WIDTH-1:0] {
    eIdle  = 3'd0,
    eIssue = 3'd1,
    eWait  = 3'd2,
    eFix   = 3'd3,
    eDone  = 3'd4
  } mul_state_e;

  // Mulhsu runs unsigned on the core and is corrected afterwards.
  function automatic logic core_signed(input mul_op_e op);
    return (op == eMulh) || (op == eMulw);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_mul_result_format.sv
// ============================================================================
// bsg_mul_result_format : selects/corrects the architectural result from a full product
// Rev 1.0
// ============================================================================
`default_nettype none

module bsg_mul_result_format
  import bsg_mul_op_pkg::*;
#(
  parameter int width_p = 64
) (
  input  mul_op_e                  op_i,
  input  logic [2*width_p-1:0]     product_i,
  input  logic                     opA_sign_i,
  input  logic [width_p-1:0]       opB_i,
  output logic [width_p-1:0]       result_o
);

  localparam int HALF = width_p / 2;

  logic [width_p-1:0] prod_hi;
  logic [width_p-1:0] prod_lo;
  logic [width_p-1:0] prod_word;
  logic [width_p-1:0] correction;

  always_comb begin
    prod_hi    = product_i[2*width_p-1:width_p];
    prod_lo    = product_i[width_p-1:0];
    prod_word  = {{HALF{product_i[HALF-1]}}, product_i[HALF-1:0]};
    // Unsigned rs2 times signed rs1: a negative rs1 was seen as rs1 + 2^width_p.
    correction = opA_sign_i ? opB_i : '0;
  end

  always_comb begin
    result_o = prod_lo;
    case (op_i)
      eMul:           result_o = prod_lo;
      eMulh, eMulhu:  result_o = prod_hi;
      eMulhsu:        result_o = prod_hi - correction;
      eMulw:          result_o = prod_word;
      default:        result_o = prod_lo;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bsg_mul_op_sequencer.sv
// ============================================================================
// bsg_mul_op_sequencer : issues M-extension multiplies to an iterative core and formats results
// Rev 1.0
// ============================================================================
`default_nettype none

module bsg_mul_op_sequencer
  import bsg_mul_op_pkg::*;
#(
  parameter int width_p = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  output logic                    ready_o,
  input  logic                    v_i,
  input  logic [2:0]              op_i,
  input  logic [width_p-1:0]      opA_i,
  input  logic [width_p-1:0]      opB_i,

  output logic [width_p-1:0]      result_o,
  output logic                    v_o,
  input  logic                    yumi_i,

  input  logic                    core_ready_i,
  output logic                    core_v_o,
  output logic [width_p-1:0]      core_opA_o,
  output logic [width_p-1:0]      core_opB_o,
  output logic                    core_signed_o,
  input  logic [2*width_p-1:0]    core_result_i,
  input  logic                    core_v_i,
  output logic                    core_yumi_o
);

  localparam int HALF = width_p / 2;

  mul_state_e             state_q, state_d;
  mul_op_e                op_q, op_d;
  logic [width_p-1:0]     opa_q, opa_d;
  logic [width_p-1:0]     opb_q, opb_d;
  logic [2*width_p-1:0]   prod_q, prod_d;
  logic [width_p-1:0]     fix_q, fix_d;

  logic [width_p-1:0]     fmt_result;

  bsg_mul_result_format #(
    .width_p (width_p)
  ) u_format (
    .op_i       (op_q),
    .product_i  (prod_q),
    .opA_sign_i (opa_q[width_p-1]),
    .opB_i      (opb_q),
    .result_o   (fmt_result)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= eIdle;
      op_q    <= eMul;
      opa_q   <= '0;
      opb_q   <= '0;
      prod_q  <= '0;
      fix_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      prod_q  <= prod_d;
      fix_q   <= fix_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    prod_d      = prod_q;
    fix_d       = fix_q;
    ready_o     = 1'b0;
    core_v_o    = 1'b0;
    core_yumi_o = 1'b0;
    v_o         = 1'b0;

    case (state_q)
      eIdle: begin
        ready_o = 1'b1;
        if (v_i) begin
          op_d    = mul_op_e'(op_i);
          opa_d   = opA_i;
          opb_d   = opB_i;
          state_d = eIssue;
        end
      end
      eIssue: begin
        core_v_o = 1'b1;
        if (core_ready_i) begin
          state_d = eWait;
        end
      end
      eWait: begin
        core_yumi_o = core_v_i;
        if (core_v_i) begin
          prod_d  = core_result_i;
          state_d = (op_q == eMulhsu) ? eFix : eDone;
        end
      end
      eFix: begin
        fix_d   = fmt_result;
        state_d = eDone;
      end
      eDone: begin
        v_o = 1'b1;
        if (yumi_i) begin
          state_d = eIdle;
        end
      end
      default: begin
        state_d = eIdle;
      end
    endcase
  end

  // Word ops present the low halves sign-extended so the core sees 32x32 signed.
  always_comb begin
    core_signed_o = core_signed(op_q);
    if (op_q == eMulw) begin
      core_opA_o = {{HALF{opa_q[HALF-1]}}, opa_q[HALF-1:0]};
      core_opB_o = {{HALF{opb_q[HALF-1]}}, opb_q[HALF-1:0]};
    end else begin
      core_opA_o = opa_q;
      core_opB_o = opb_q;
    end
  end

  assign result_o = (op_q == eMulhsu) ? fix_q : fmt_result;

endmodule

`default_nettype wire

// File: doc/bsg_mul_op_sequencer.md
BSG_MUL_OP_SEQUENCER -- requirements
Module: bsg_mul_op_sequencer

Interface
REQ-001 Parameter: width_p, default 64, operand width; SHALL be even and at least 8.
REQ-002 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset_i  input  1  asynchronous, active-high reset.
REQ-004 Port: ready_o  output  1  block can accept an op this cycle.
REQ-005 Port: v_i  input  1  op request valid; the op is accepted when v_i & ready_o.
REQ-006 Port: op_i  input  3  op code, from the package enum: eMul, eMulh, eMulhsu, eMulhu, eMulw.
REQ-007 Port: opA_i / opB_i  input  width_p each  rs1 / rs2 operands.
REQ-008 Port: result_o  output  width_p  formatted result.
REQ-009 Port: v_o  output  1  result_o valid.
REQ-010 Port: yumi_i  input  1  consumer takes the result; legal only while v_o=1.
REQ-011 Port: core_ready_i  input  1  iterative multiplier core is idle.
REQ-012 Port: core_v_o  output  1  issue request to the core.
REQ-013 Port: core_opA_o / core_opB_o  output  width_p each  operands to the core.
REQ-014 Port: core_signed_o  output  1  signedness flag to the core; applies to both operands.
REQ-015 Port: core_result_i  input  2*width_p  full product from the core.
REQ-016 Port: core_v_i  input  1  core product valid.
REQ-017 Port: core_yumi_o  output  1  consume the core product.

Function
REQ-018 FSM states SHALL be eIdle, eIssue, eWait, eFix, eDone.
REQ-019 eIdle behaviour:
- ready_o=1.
- On v_i, latch op, opA and opB, then go to eIssue.
- In every other state ready_o=0 and v_i is ignored.
REQ-020 eIssue behaviour:
- core_v_o=1.
- Go to eWait in the cycle core_ready_i=1.
- Otherwise hold, with core_* outputs stable.
REQ-021 eWait behaviour:
- core_yumi_o = core_v_i, combinational.
- On core_v_i, latch core_result_i.
- Go to eFix if the op is eMulhsu, else go to eDone.
- core_yumi_o=0 in every other state.
REQ-022 Issue mapping to the core:
- eMul / eMulhu / eMulhsu: operands unchanged, core_signed_o=0.
- eMulh: operands unchanged, core_signed_o=1.
- eMulw: each operand sign-extended from bit width_p/2-1, core_signed_o=1.
REQ-023 Result formatting:
- eMul: product[width_p-1:0].
- eMulh / eMulhu: product[2*width_p-1:width_p].
- eMulw: product[width_p/2-1:0] sign-extended to width_p.
REQ-024 eFix SHALL take one cycle and register high = product[2*width_p-1:width_p] minus (opA[width_p-1] ? opB : 0), modulo 2^width_p, then go to eDone.
REQ-025 eDone behaviour:
- v_o=1 and result_o held stable.
- On yumi_i, go to eIdle.
- The next op can be accepted no earlier than the following cycle; there is no bypass.
REQ-026 Latency from acceptance to v_o:
- One cycle in eIssue plus core stall, plus the core latency.
- Plus one cycle for eMulhsu.
- Stall while v_o=1 and yumi_i=0 is unbounded, with result_o stable.
REQ-027 Core back-pressure:
- core_ready_i low holds the block in eIssue indefinitely.
- core_v_i arriving in any state other than eWait SHALL be ignored, with no yumi.
REQ-028 The op code latched at acceptance SHALL govern the whole operation; op_i changes after acceptance have no effect.

Reset
REQ-029 Reset SHALL force state to eIdle at any point, including mid-eWait.
REQ-030 Output values while in reset: ready_o=1 once state is eIdle; v_o=0, core_v_o=0, core_yumi_o=0, result_o=0.
REQ-031 All operand, op and product registers SHALL clear to 0.
REQ-032 A core product pending at reset SHALL NOT be yumi'd by this block; the core is reset by the same reset_i.

Structure
REQ-033 Package bsg_mul_op_pkg SHALL hold the op enum (3 bits) and the FSM state enum.
REQ-034 Sub-module bsg_mul_result_format SHALL be purely combinational.
- Inputs: op, product, opA sign bit, opB.
- Output: formatted or corrected width_p result.
- The eFix register sits in the parent.

Verification (width_p=64)
REQ-035 eMul, A=3, B=5 -> result_o=0x0000_0000_0000_000F; core_signed_o=0 at issue.
REQ-036 eMulh, A=B=0xFFFF_FFFF_FFFF_FFFF -> result_o=0. eMulhu, same operands -> result_o=0xFFFF_FFFF_FFFF_FFFE.
REQ-037 eMulhsu, A=0xFFFF_FFFF_FFFF_FFFF, B=2:
- Core high = 1, corrected to result_o=0xFFFF_FFFF_FFFF_FFFF.
- v_o rises exactly one cycle later than for eMulhu.
REQ-038 eMulw, A=0x7FFF_FFFF, B=2 -> result_o=0xFFFF_FFFF_FFFF_FFFE.
REQ-039 Back-pressure:
- Hold core_ready_i=0 for 5 cycles: core_v_o stays 1 with operands stable.
- Hold yumi_i=0 for 10 cycles: v_o and result_o stable.
- v_i pulses during these stalls are not accepted.
REQ-040 Assert reset_i while in eWait: next state eIdle, v_o=0, core_yumi_o=0. A following eMul, A=B=7 -> 0x31.
